// File: rtl/risc_controller_pkg.sv
// Shared opcode map, control encodings and the control word
// carried from the decoder into the output register.
package risc_controller_pkg;

   localparam logic [5:0] OP_RTYPE  = 6'd0;
   localparam logic [5:0] OP_SHIFTI = 6'd1;
   localparam logic [5:0] OP_SHIFTV = 6'd2;
   localparam logic [5:0] OP_ADDI   = 6'd3;
   localparam logic [5:0] OP_COMPI  = 6'd4;
   localparam logic [5:0] OP_LW     = 6'd5;
   localparam logic [5:0] OP_SW     = 6'd6;
   localparam logic [5:0] OP_BR     = 6'd7;
   localparam logic [5:0] OP_BLTZ   = 6'd8;
   localparam logic [5:0] OP_BZ     = 6'd9;
   localparam logic [5:0] OP_BNZ    = 6'd10;
   localparam logic [5:0] OP_B      = 6'd11;
   localparam logic [5:0] OP_BL     = 6'd12;
   localparam logic [5:0] OP_BCY    = 6'd13;
   localparam logic [5:0] OP_BNCY   = 6'd14;

   typedef enum logic [2:0] {
      ALU_NONE  = 3'b000,
      ALU_RTYPE = 3'b001,
      ALU_SHIFT = 3'b010,
      ALU_ADD   = 3'b011,
      ALU_COMP  = 3'b100
   } alu_op_e;

   typedef enum logic [2:0] {
      SRC_RT    = 3'b000,
      SRC_SHAMT = 3'b001,
      SRC_IMM   = 3'b010,
      SRC_MOFF  = 3'b011
   } alu_src_e;

   typedef enum logic [1:0] {
      RD_RS  = 2'b00,
      RD_RT  = 2'b01,
      RD_R31 = 2'b10
   } reg_dest_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC4 = 2'b10
   } wb_src_e;

   typedef enum logic [1:0] {
      BC_LTZ = 2'b00,
      BC_EQZ = 2'b01,
      BC_NEZ = 2'b10
   } bcomp_e;

   typedef struct packed {
      alu_op_e   alu_op;
      alu_src_e  alu_src;
      logic      mem_write;
      logic      reg_write;
      reg_dest_e reg_dest;
      wb_src_e   wb_src;
      logic      br_reg;
      logic      br_comp;
      bcomp_e    br_comp_type;
      logic      br_uncond;
      logic      br_carry;
      logic      br_carry_set;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/risc_controller_decode.sv
// Combinational opcode to control-word table; unknown
// opcodes fall through to the all-zero NOP word.
module controller_decode
   import risc_controller_pkg::*;
(
   input  logic [5:0] i_opcode,
   output ctrl_t      o_ctrl
);

   always_comb begin
      o_ctrl = CTRL_NOP;
      case (i_opcode)
         OP_RTYPE: begin
            o_ctrl.alu_op    = ALU_RTYPE;
            o_ctrl.alu_src   = SRC_RT;
            o_ctrl.reg_write = 1'b1;
            o_ctrl.reg_dest  = RD_RS;
            o_ctrl.wb_src    = WB_ALU;
         end
         OP_SHIFTI: begin
            o_ctrl.alu_op    = ALU_SHIFT;
            o_ctrl.alu_src   = SRC_SHAMT;
            o_ctrl.reg_write = 1'b1;
         end
         OP_SHIFTV: begin
            o_ctrl.alu_op    = ALU_SHIFT;
            o_ctrl.alu_src   = SRC_RT;
            o_ctrl.reg_write = 1'b1;
         end
         OP_ADDI: begin
            o_ctrl.alu_op    = ALU_ADD;
            o_ctrl.alu_src   = SRC_IMM;
            o_ctrl.reg_write = 1'b1;
         end
         OP_COMPI: begin
            o_ctrl.alu_op    = ALU_COMP;
            o_ctrl.alu_src   = SRC_IMM;
            o_ctrl.reg_write = 1'b1;
         end
         OP_LW: begin
            o_ctrl.alu_op    = ALU_ADD;
            o_ctrl.alu_src   = SRC_MOFF;
            o_ctrl.reg_write = 1'b1;
            o_ctrl.reg_dest  = RD_RT;
            o_ctrl.wb_src    = WB_MEM;
         end
         OP_SW: begin
            o_ctrl.alu_op    = ALU_ADD;
            o_ctrl.alu_src   = SRC_MOFF;
            o_ctrl.mem_write = 1'b1;
         end
         OP_BR: o_ctrl.br_reg = 1'b1;
         OP_BLTZ: begin
            o_ctrl.br_comp      = 1'b1;
            o_ctrl.br_comp_type = BC_LTZ;
         end
         OP_BZ: begin
            o_ctrl.br_comp      = 1'b1;
            o_ctrl.br_comp_type = BC_EQZ;
         end
         OP_BNZ: begin
            o_ctrl.br_comp      = 1'b1;
            o_ctrl.br_comp_type = BC_NEZ;
         end
         OP_B: o_ctrl.br_uncond = 1'b1;
         OP_BL: begin
            // link: PC+4 is written into r31
            o_ctrl.br_uncond = 1'b1;
            o_ctrl.reg_write = 1'b1;
            o_ctrl.reg_dest  = RD_R31;
            o_ctrl.wb_src    = WB_PC4;
         end
         OP_BCY: begin
            o_ctrl.br_carry     = 1'b1;
            o_ctrl.br_carry_set = 1'b1;
         end
         OP_BNCY: begin
            o_ctrl.br_carry     = 1'b1;
            o_ctrl.br_carry_set = 1'b0;
         end
         default: o_ctrl = CTRL_NOP;
      endcase
   end

endmodule

// File: rtl/risc_controller.sv
// Main decoder: table lookup followed by one reset-qualified
// output register, so every control signal is glitch-free.
module risc_controller
   import risc_controller_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   output logic [2:0] aluOp,
   output logic [2:0] aluSrc,
   output logic       memWrite,
   output logic       regWrite,
   output logic [1:0] regDest,
   output logic [1:0] mem2RegData,
   output logic       branchReg,
   output logic       branchComp,
   output logic [1:0] branchCompType,
   output logic       branchNoRegNoCond,
   output logic       branchCarryDep,
   output logic       branchCarryType
);

   ctrl_t w_ctrl;
   ctrl_t r_ctrl;

   controller_decode u_decode (
      .i_opcode (opcode),
      .o_ctrl   (w_ctrl)
   );

   always_ff @(posedge clk) begin
      if (rst) r_ctrl <= CTRL_NOP;
      else     r_ctrl <= w_ctrl;
   end

   assign aluOp             = r_ctrl.alu_op;
   assign aluSrc            = r_ctrl.alu_src;
   assign memWrite          = r_ctrl.mem_write;
   assign regWrite          = r_ctrl.reg_write;
   assign regDest           = r_ctrl.reg_dest;
   assign mem2RegData       = r_ctrl.wb_src;
   assign branchReg         = r_ctrl.br_reg;
   assign branchComp        = r_ctrl.br_comp;
   assign branchCompType    = r_ctrl.br_comp_type;
   assign branchNoRegNoCond = r_ctrl.br_uncond;
   assign branchCarryDep    = r_ctrl.br_carry;
   assign branchCarryType   = r_ctrl.br_carry_set;

endmodule

// File: tb/tb_risc_controller.sv
// Self-checking bench: expected-word table model, per-cycle
// compare with invariants, plus directed literal checks.
module tb_risc_controller;

   logic       clk;
   logic       rst;
   logic [5:0] opcode;
   logic [2:0] aluOp;
   logic [2:0] aluSrc;
   logic       memWrite;
   logic       regWrite;
   logic [1:0] regDest;
   logic [1:0] mem2RegData;
   logic       branchReg;
   logic       branchComp;
   logic [1:0] branchCompType;
   logic       branchNoRegNoCond;
   logic       branchCarryDep;
   logic       branchCarryType;

   int checks = 0;
   int errors = 0;

   risc_controller dut (
      .clk               (clk),
      .rst               (rst),
      .opcode            (opcode),
      .aluOp             (aluOp),
      .aluSrc            (aluSrc),
      .memWrite          (memWrite),
      .regWrite          (regWrite),
      .regDest           (regDest),
      .mem2RegData       (mem2RegData),
      .branchReg         (branchReg),
      .branchComp        (branchComp),
      .branchCompType    (branchCompType),
      .branchNoRegNoCond (branchNoRegNoCond),
      .branchCarryDep    (branchCarryDep),
      .branchCarryType   (branchCarryType)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // aluOp aluSrc mw rw rd m2r bR bC bCT bN bCD bCT
   logic [18:0] tbl [0:14];
   initial begin
      tbl[0]  = {3'b001, 3'b000, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
      tbl[1]  = {3'b010, 3'b001, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
      tbl[2]  = {3'b010, 3'b000, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
      tbl[3]  = {3'b011, 3'b010, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
      tbl[4]  = {3'b100, 3'b010, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
      tbl[5]  = {3'b011, 3'b011, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000};
      tbl[6]  = {3'b011, 3'b011, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
      tbl[7]  = {3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 3'b000};
      tbl[8]  = {3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000};
      tbl[9]  = {3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 3'b000};
      tbl[10] = {3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 3'b000};
      tbl[11] = {3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100};
      tbl[12] = {3'b000, 3'b000, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 3'b100};
      tbl[13] = {3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b011};
      tbl[14] = {3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010};
   end

   function automatic logic [18:0] model(input logic r, input logic [5:0] op);
      if (r || op > 6'd14) return '0;
      return tbl[op];
   endfunction

   logic [18:0] w_out;
   assign w_out = {aluOp, aluSrc, memWrite, regWrite, regDest,
                   mem2RegData, branchReg, branchComp, branchCompType,
                   branchNoRegNoCond, branchCarryDep, branchCarryType};

   logic [18:0] exp_q;
   logic [5:0]  op_q;
   logic        vld = 1'b0;

   always @(posedge clk) begin
      exp_q <= model(rst, opcode);
      op_q  <= opcode;
      vld   <= 1'b1;
   end

   always @(negedge clk) begin
      if (vld) begin
         checks++;
         if (w_out !== exp_q) begin
            errors++;
            $display("FAIL word op=%0d got=%b want=%b", op_q, w_out, exp_q);
         end
         checks++;
         if ((int'(branchReg) + int'(branchComp) +
              int'(branchNoRegNoCond) + int'(branchCarryDep)) > 1) begin
            errors++;
            $display("FAIL br_onehot op=%0d got=%b%b%b%b want<=1 set",
                     op_q, branchReg, branchComp,
                     branchNoRegNoCond, branchCarryDep);
         end
         checks++;
         if (memWrite && regWrite) begin
            errors++;
            $display("FAIL mw_rw_excl op=%0d got=11 want!=11", op_q);
         end
      end
   end

   task automatic apply(input logic [5:0] op, input logic r);
      @(negedge clk);
      opcode = op;
      rst    = r;
   endtask

   task automatic hand(input string nm, input logic [18:0] want);
      @(posedge clk);
      #1;
      checks++;
      if (w_out !== want) begin
         errors++;
         $display("FAIL %s got=%b want=%b", nm, w_out, want);
      end
   endtask

   initial begin
      opcode = 6'd5;
      rst    = 1'b1;
      @(posedge clk);
      hand("reset", 19'b0);
      apply(6'd5, 1'b0);
      hand("lw_after_reset",
           {3'b011, 3'b011, 1'b0, 1'b1, 2'b01, 2'b01, 7'b0});
      for (int i = 0; i < 15; i++) apply(6'(i), 1'b0);
      apply(6'd12, 1'b0);
      hand("bl", {6'b0, 1'b0, 1'b1, 2'b10, 2'b10, 4'b0, 3'b100});
      apply(6'd15, 1'b0);
      hand("op15", 19'b0);
      apply(6'd31, 1'b0);
      hand("op31", 19'b0);
      apply(6'd63, 1'b0);
      hand("op63", 19'b0);
      apply(6'd6, 1'b0);
      hand("sw", {3'b011, 3'b011, 1'b1, 1'b0, 11'b0});
      apply(6'd8, 1'b0);
      hand("bltz", {12'b0, 1'b0, 1'b1, 2'b00, 3'b000});
      apply(6'd13, 1'b0);
      hand("bcy", {16'b0, 3'b011});
      apply(6'd14, 1'b0);
      hand("bncy", {16'b0, 3'b010});
      apply(6'd3, 1'b1);
      hand("reset_mid", 19'b0);
      for (int i = 0; i < 400; i++) begin
         logic [5:0] op;
         op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                          : 6'($urandom_range(0, 14));
         apply(op, ($urandom_range(0, 15) == 0));
      end
      apply(6'd0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/risc_controller.md
# risc_controller

Main decoder of the single-cycle RISC core. Maps the 6-bit instruction opcode to every datapath control signal: ALU operation class, ALU operand source, register write enable/destination, write-back source, memory write, and the branch-type flags. Decode is a pure truth table, and all outputs are registered on a single clock. The block sits between instruction fetch and the datapath/branch unit.

## Interface
- No parameters.
- clk  in  1  system clock; all outputs update on its rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instruction opcode field.
- aluOp  out  3  ALU class: 000 none, 001 R-type (funct-decoded), 010 shift (funct-decoded), 011 add, 100 complement.
- aluSrc  out  3  ALU operand B: 000 rt, 001 shamt, 010 sign-extended immediate, 011 sign-extended memory offset.
- memWrite  out  1  data-memory write enable.
- regWrite  out  1  register-file write enable.
- regDest  out  2  write register: 00 rs, 01 rt, 10 r31 (link).
- mem2RegData  out  2  write-back data: 00 ALU result, 01 memory read data, 10 PC+4.
- branchReg  out  1  jump to the address in register rs.
- branchComp  out  1  conditional branch on the rs value.
- branchCompType  out  2  condition: 00 rs<0, 01 rs==0, 10 rs!=0.
- branchNoRegNoCond  out  1  unconditional PC-relative branch.
- branchCarryDep  out  1  branch depends on the carry flag.
- branchCarryType  out  1  1 = branch if carry set, 0 = branch if carry clear.

## Operation
All signals not listed for an opcode are 0.
- 0 R-type ALU: aluOp=001, aluSrc=000, regWrite=1, regDest=00, mem2RegData=00.
- 1 shift by shamt: aluOp=010, aluSrc=001, regWrite=1.
- 2 shift variable: aluOp=010, aluSrc=000, regWrite=1.
- 3 addi: aluOp=011, aluSrc=010, regWrite=1.
- 4 compi: aluOp=100, aluSrc=010, regWrite=1.
- 5 lw: aluOp=011, aluSrc=011, regWrite=1, regDest=01, mem2RegData=01.
- 6 sw: aluOp=011, aluSrc=011, memWrite=1.
- 7 br: branchReg=1.
- 8 bltz: branchComp=1, branchCompType=00.
- 9 bz: branchComp=1, branchCompType=01.
- 10 bnz: branchComp=1, branchCompType=10.
- 11 b: branchNoRegNoCond=1.
- 12 bl: branchNoRegNoCond=1, regWrite=1, regDest=10, mem2RegData=10.
- 13 bcy: branchCarryDep=1, branchCarryType=1.
- 14 bncy: branchCarryDep=1, branchCarryType=0.
- 15–63 (undefined): NOP, all outputs 0. The block never writes a register or memory for these opcodes.
- At most one of branchReg, branchComp, branchNoRegNoCond, branchCarryDep is 1 in any cycle.
- memWrite and regWrite are never both 1.

## Timing
- Latency: 1 cycle. The opcode sampled at rising edge N is decoded and presented on the outputs after edge N, and held until the next edge.
- Reset: a rising edge with rst=1 forces every output to 0 (the NOP word), regardless of opcode. Reset has priority over decode.
- Reset mid-stream: the cycle after rst deasserts, the outputs reflect the opcode sampled at that edge. No state is retained.
- No handshake and no internal state beyond the output register.

## Structure
- Shared package holds:
  - opcode constants (OP_RTYPE=0 … OP_BNCY=14)
  - aluOp, aluSrc, regDest and mem2RegData encodings
  - branchCompType encodings
  - the all-zero NOP control word
- One sub-module: controller_decode, a purely combinational opcode-to-control-word case statement with a default of NOP. risc_controller wraps it with the reset-qualified output register.

## Test plan
- Reset: assert rst for 2 cycles with opcode=5 -> all outputs 0. Deassert -> next cycle aluOp=011, aluSrc=011, regWrite=1, regDest=01, mem2RegData=01.
- Opcode sweep 0..14, one per cycle -> each cycle's outputs match the Operation table exactly, one cycle after the opcode was applied.
- Opcode 12 (bl) -> branchNoRegNoCond=1, regWrite=1, regDest=10, mem2RegData=10, memWrite=0.
- Opcodes 15, 31, 63 -> all outputs 0.
- Opcode 6 then 8 on back-to-back cycles:
  - first output cycle: memWrite=1, regWrite=0.
  - second output cycle: branchComp=1, branchCompType=00, memWrite=0.
- Opcodes 13/14 -> branchCarryDep=1, with branchCarryType=1 for 13 and 0 for 14. Throughout the sweep, assert the one-hot branch-flag and memWrite/regWrite exclusivity checks every cycle.
